// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard receiver that turns extended arrow-key scan codes into one-cycle
// clk-domain pulses, per-key held levels and a frame error pulse.
module ps2_arrow_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter bit          REPEAT_EN      = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left,
    output logic       right,
    output logic       down,
    output logic       up,
    output logic [3:0] key_held,
    output logic       frame_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Synchronizer and edge-detect registers; idle bus level is high
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;

    // Receiver and decoder state
    state_e            r_state, w_state_d;
    logic [2:0]        r_bit_cnt, w_bit_cnt_d;
    logic [7:0]        r_shift, w_shift_d;
    logic              r_parity, w_parity_d;
    logic [CntW-1:0]   r_to_cnt, w_to_cnt_d;
    logic              r_ext, w_ext_d;
    logic              r_brk, w_brk_d;
    logic [3:0]        r_held, w_held_d;
    logic [3:0]        r_pulse, w_pulse_d;
    logic              r_err, w_err_d;

    logic       w_fall;
    logic       w_dat;
    logic       w_timeout;
    logic       w_valid;
    logic [3:0] w_arrow;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_dat     = r_dat_s2;
    assign w_timeout = (r_state != StIdle) && (r_to_cnt == CntW'(TIMEOUT_CYCLES));
    // Odd parity over data plus parity bit, and a high stop bit
    assign w_valid   = w_dat & (^{r_shift, r_parity});

    // Two-flop synchronizers plus previous-clock register for fall detection
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    // Map the received byte to a one-hot arrow index {up,down,right,left}
    always_comb begin
        w_arrow = 4'b0000;
        case (r_shift)
            8'h6B:   w_arrow = 4'b0001;
            8'h74:   w_arrow = 4'b0010;
            8'h72:   w_arrow = 4'b0100;
            8'h75:   w_arrow = 4'b1000;
            default: w_arrow = 4'b0000;
        endcase
    end

    // Inactivity counter: runs only while a frame is in progress
    always_comb begin
        w_to_cnt_d = r_to_cnt + CntW'(1);
        if (w_fall || (r_state == StIdle) || w_timeout) begin
            w_to_cnt_d = '0;
        end
    end

    // Receiver FSM next-state, prefix tracking and arrow decode
    always_comb begin
        w_state_d   = r_state;
        w_bit_cnt_d = r_bit_cnt;
        w_shift_d   = r_shift;
        w_parity_d  = r_parity;
        w_ext_d     = r_ext;
        w_brk_d     = r_brk;
        w_held_d    = r_held;
        w_pulse_d   = 4'b0000;
        w_err_d     = 1'b0;
        if (w_fall) begin
            unique case (r_state)
                StIdle: begin
                    if (!w_dat) begin
                        w_state_d   = StData;
                        w_bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    w_shift_d   = {w_dat, r_shift[7:1]};
                    w_bit_cnt_d = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_d = StParity;
                    end
                end
                StParity: begin
                    w_parity_d = w_dat;
                    w_state_d  = StStop;
                end
                StStop: begin
                    w_state_d = StIdle;
                    if (!w_valid) begin
                        w_err_d = 1'b1;
                        w_ext_d = 1'b0;
                        w_brk_d = 1'b0;
                    end else if (r_shift == 8'hE0) begin
                        w_ext_d = 1'b1;
                    end else if (r_shift == 8'hF0) begin
                        w_brk_d = 1'b1;
                    end else begin
                        if (r_ext && (|w_arrow)) begin
                            if (r_brk) begin
                                w_held_d = r_held & ~w_arrow;
                            end else begin
                                // Without repeat, typematic makes of a held key stay silent
                                if (REPEAT_EN || !(|(r_held & w_arrow))) begin
                                    w_pulse_d = w_arrow;
                                end
                                w_held_d = r_held | w_arrow;
                            end
                        end
                        w_ext_d = 1'b0;
                        w_brk_d = 1'b0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end else if (w_timeout) begin
            // Abandoned partial frame: drop it and any pending prefix
            w_state_d = StIdle;
            w_ext_d   = 1'b0;
            w_brk_d   = 1'b0;
        end
    end

    // State register for receiver, prefixes, held levels and output pulses
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= StIdle;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            r_to_cnt  <= '0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_held    <= 4'b0000;
            r_pulse   <= 4'b0000;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_shift   <= w_shift_d;
            r_parity  <= w_parity_d;
            r_to_cnt  <= w_to_cnt_d;
            r_ext     <= w_ext_d;
            r_brk     <= w_brk_d;
            r_held    <= w_held_d;
            r_pulse   <= w_pulse_d;
            r_err     <= w_err_d;
        end
    end

    assign left      = r_pulse[0];
    assign right     = r_pulse[1];
    assign down      = r_pulse[2];
    assign up        = r_pulse[3];
    assign key_held  = r_held;
    assign frame_err = r_err;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Scoreboard bench for ps2_arrow_decoder: a frame-level model predicts each
// pulse/error and the clk cycle it should appear in; a monitor pops and compares.
module tb_ps2_arrow_decoder;

    localparam int TO_CYC = 600;  // shortened timeout so the abort case stays cheap
    localparam int HALF   = 20;   // PS/2 half period in clk cycles
    localparam int GAP    = 30;   // idle clk cycles between frames

    typedef struct {
        logic [3:0] pulse;  // {up,down,right,left}
        logic       err;
        int         cyc;    // clk cycle count at which the output must be seen
    } exp_t;

    logic       clk;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       left, right, down, up;
    logic [3:0] key_held;
    logic       frame_err;

    int   cyc;
    int   checks;
    int   errors;
    exp_t q[$];

    // Reference model state
    logic       m_ext;
    logic       m_brk;
    logic [3:0] m_held;

    ps2_arrow_decoder #(
        .TIMEOUT_CYCLES(TO_CYC),
        .REPEAT_EN     (1'b0)
    ) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .left     (left),
        .right    (right),
        .down     (down),
        .up       (up),
        .key_held (key_held),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Frame-level behaviour: push an expected event for the stop-bit fall
    task automatic model_byte(input logic [7:0] b, input bit ok, input int at);
        exp_t       e;
        logic [3:0] idx;
        e.pulse = 4'b0000;
        e.err   = 1'b0;
        e.cyc   = at;
        case (b)
            8'h6B:   idx = 4'b0001;
            8'h74:   idx = 4'b0010;
            8'h72:   idx = 4'b0100;
            8'h75:   idx = 4'b1000;
            default: idx = 4'b0000;
        endcase
        if (!ok) begin
            e.err = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (m_ext && idx != 4'b0000) begin
                if (m_brk) begin
                    m_held = m_held & ~idx;
                end else begin
                    if ((m_held & idx) == 4'b0000) e.pulse = idx;
                    m_held = m_held | idx;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        if (e.pulse != 4'b0000 || e.err) q.push_back(e);
    endtask

    // Drive the first nbits of a frame; a flipped parity bit makes it invalid.
    // The pin falls at a negedge; two sync edges plus one output edge later the
    // result is visible, i.e. in the fourth clk cycle counting the pin's own.
    task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (i == 10) model_byte(b, !bad, cyc + 3);
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
        if (nbits == 11) check_eq($sformatf("held_after_%02h", b), 32'(key_held), 32'(m_held));
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_pulses"}, 32'({up, down, right, left}), 32'd0);
        check_eq({tag, "_err"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_held"}, 32'(key_held), 32'(m_held));
    endtask

    // Monitor: every output event must match the head of the scoreboard
    always @(negedge clk) begin : mon
        logic [3:0] obs;
        exp_t       e;
        if (clrn) begin
            obs = {up, down, right, left};
            if (obs != 4'b0000 || frame_err) begin
                if (q.size() == 0) begin
                    check_eq("unexpected_out", 32'({obs, frame_err}), 32'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("pulse", 32'(obs), 32'(e.pulse));
                    check_eq("frame_err", 32'(frame_err), 32'(e.err));
                    check_eq("latency", 32'(cyc), 32'(e.cyc));
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                e = q.pop_front();
                check_eq("missing_out", 32'({obs, frame_err}), 32'({e.pulse, e.err}));
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        m_ext    = 1'b0;
        m_brk    = 1'b0;
        m_held   = 4'b0000;
        clrn     = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check_quiet("reset");
        clrn = 1'b1;
        repeat (20) @(negedge clk);
        check_quiet("idle_bus");

        // Up arrow make
        send(8'hE0);
        send(8'h75);

        // Left twice without repeat, break, then make again
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h6B);
        send(8'hE0); send(8'h6B);

        // Bad parity clears the pending E0; plain 72 must then stay silent
        send(8'hE0);
        send_frame(8'h72, 1'b1, 11);
        send(8'h72);
        send(8'hE0); send(8'h72);

        // Non-extended 74 is not Right
        send(8'h74);
        send(8'hE0); send(8'h74);

        // Release down, then abort a frame by timeout after an E0
        send(8'hE0); send(8'hF0); send(8'h72);
        send(8'hE0);
        send_frame(8'h3C, 1'b0, 5);
        repeat (TO_CYC + 200) @(negedge clk);
        m_ext = 1'b0;
        m_brk = 1'b0;
        check_quiet("after_timeout");
        send(8'h72);
        send(8'hE0); send(8'h72);

        // Reset in the middle of a frame that follows an E0
        send(8'hE0);
        send_frame(8'h72, 1'b0, 5);
        clrn = 1'b0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_held = 4'b0000;
        repeat (5) @(negedge clk);
        check_quiet("mid_reset");
        clrn = 1'b1;
        repeat (10) @(negedge clk);
        send(8'h72);
        check_quiet("after_reset");

        repeat (50) @(negedge clk);
        check_eq("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
